bcd_digit_accumulator: RTL and testbench

- Sequential decimal-to-binary converter; inverse of the combinational binary-to-digit splitter used for display.
- Accepts decimal digits one per handshake, most significant first, and accumulates value = value*BASE + digit.
- Sits between keypad/button-entry logic (debounced, edge-detected digit strobes) and game logic that needs a binary guess/count.
- Emits the finished number through a valid/ready output handshake.

---
 rtl/bcd_digit_accumulator.sv | 198 +++++++++++++++++++
 tb/tb_bcd_digit_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_accumulator.sv
// bcd_digit_accumulator: sequential decimal-to-binary converter.
// Digits arrive most significant first on a valid/ready handshake and are
// folded into value = value*BASE + digit. The finished number is offered on
// a valid/ready output handshake.
// Optional macro BCD_ACC_TIMEOUT_EN adds an idle-cycle timeout in ACCUM.
module bcd_digit_accumulator #(
  parameter int unsigned W_OUT          = 9,
  parameter int unsigned MAX_DIGITS     = 3,
  parameter int unsigned BASE           = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic [W_OUT-1:0] value,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             overflow,
  output logic             bad_digit,
  output logic             busy
);

  localparam int unsigned ACC_W = W_OUT + 5;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  // Elaboration-time parameter range checks
  if (MAX_DIGITS < 1 || MAX_DIGITS > 15) begin : g_bad_max_digits
    $error("MAX_DIGITS must be in 1..15");
  end
  if (BASE < 2 || BASE > 16) begin : g_bad_base
    $error("BASE must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t           state_q, state_d;
  logic [W_OUT-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic [W_OUT-1:0] value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic             digit_ready_q, digit_ready_d;
  logic             overflow_q, overflow_d;
  logic             bad_digit_q, bad_digit_d;
  logic             busy_q, busy_d;

  logic             digit_ok;
  logic [3:0]       digit_eff;
  logic [ACC_W-1:0] next_wide;
  logic             next_ovf;
  logic [W_OUT-1:0] next_acc;
  logic             accept;
  logic             consume;
  logic             last_count;

`ifdef BCD_ACC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q, idle_d;
  logic            idle_hit;
`endif

  // Digit datapath: multiply-accumulate with saturation
  always_comb begin
    digit_ok   = (32'(digit) < BASE);
    digit_eff  = digit_ok ? digit : 4'd0;
    next_wide  = ACC_W'(acc_q) * ACC_W'(BASE) + ACC_W'(digit_eff);
    next_ovf   = overflow_q | (|next_wide[ACC_W-1:W_OUT]);
    next_acc   = next_ovf ? {W_OUT{1'b1}} : next_wide[W_OUT-1:0];
    accept     = (state_q == S_ACCUM) & digit_ready_q & digit_valid & ~start;
    consume    = (state_q == S_DONE) & value_valid_q & value_ready;
    last_count = (4'(count_q + 4'd1) == 4'(MAX_DIGITS));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    value_d     = value_q;
    overflow_d  = overflow_q;
    bad_digit_d = bad_digit_q;
`ifdef BCD_ACC_TIMEOUT_EN
    idle_d      = '0;
    idle_hit    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ACCUM;
          acc_d       = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          bad_digit_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          acc_d       = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          bad_digit_d = 1'b0;
        end else if (accept) begin
          acc_d       = next_acc;
          overflow_d  = next_ovf;
          bad_digit_d = bad_digit_q | ~digit_ok;
          count_d     = 4'(count_q + 4'd1);
          if (digit_last || last_count) begin
            state_d = S_DONE;
            value_d = next_acc;
          end
        end else begin
`ifdef BCD_ACC_TIMEOUT_EN
          idle_d   = TO_W'(idle_q + 1'b1);
          idle_hit = (idle_d == TO_W'(TIMEOUT_CYCLES));
          if (idle_hit) begin
            idle_d = '0;
            if (count_q != 4'd0) begin
              state_d = S_DONE;
              value_d = acc_q;
            end else begin
              state_d = S_IDLE;
            end
          end
`endif
        end
      end
      S_DONE: begin
        if (consume) begin
          if (start) begin
            state_d     = S_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            bad_digit_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs rise one cycle after entering a state, drop on exit
    digit_ready_d = (state_q == S_ACCUM) & (state_d == S_ACCUM);
    value_valid_d = (state_q == S_DONE) & (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      count_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      digit_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      bad_digit_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      digit_ready_q <= digit_ready_d;
      overflow_q    <= overflow_d;
      bad_digit_q   <= bad_digit_d;
      busy_q        <= busy_d;
    end
  end

`ifdef BCD_ACC_TIMEOUT_EN
  // Idle-cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign digit_ready = digit_ready_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign overflow    = overflow_q;
  assign bad_digit   = bad_digit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Directed bench for bcd_digit_accumulator (default parameters, base 10, 9-bit).
module tb_bcd_digit_accumulator;

  localparam int unsigned W_OUT = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             digit_last;
  logic             digit_ready;
  logic [W_OUT-1:0] value;
  logic             value_valid;
  logic             value_ready;
  logic             overflow;
  logic             bad_digit;
  logic             busy;

  int total = 0;
  int bad   = 0;

  bcd_digit_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .digit_ready (digit_ready),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .overflow    (overflow),
    .bad_digit   (bad_digit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    digit       = d;
    digit_last  = l;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"},       32'(value),  0);
    check({tag, "_value_valid"}, 32'(value_valid), 0);
    check({tag, "_digit_ready"}, 32'(digit_ready), 0);
    check({tag, "_overflow"},    32'(overflow), 0);
    check({tag, "_bad_digit"},   32'(bad_digit), 0);
    check({tag, "_busy"},        32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; digit = 4'd0; digit_valid = 1'b0;
    digit_last = 1'b0; value_ready = 1'b0;
    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // 4,2,7 with last on 7 -> 427
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy_after_start", 32'(busy), 1);
    check("t1_ready_first_cycle", 32'(digit_ready), 0);
    tick();
    check("t1_ready", 32'(digit_ready), 1);
    send(4'd4, 1'b0);
    send(4'd2, 1'b0);
    send(4'd7, 1'b1);
    check("t1_ready_drop", 32'(digit_ready), 0);
    check("t1_valid_not_yet", 32'(value_valid), 0);
    tick();
    check("t1_valid", 32'(value_valid), 1);
    check("t1_value", 32'(value), 427);
    check("t1_overflow", 32'(overflow), 0);
    check("t1_bad_digit", 32'(bad_digit), 0);
    value_ready = 1'b1; tick(); value_ready = 1'b0;
    check("t1_valid_drop", 32'(value_valid), 0);
    check("t1_idle_ready", 32'(digit_ready), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_value_kept", 32'(value), 427);

    // 5,1,2 auto-complete at MAX_DIGITS, 512 saturates
    start = 1'b1; tick(); start = 1'b0; tick();
    send(4'd5, 1'b0);
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    tick();
    check("t2a_valid", 32'(value_valid), 1);
    check("t2a_value", 32'(value), 511);
    check("t2a_overflow", 32'(overflow), 1);
    // start together with consumption goes straight to ACCUM
    start = 1'b1; value_ready = 1'b1; tick();
    start = 1'b0; value_ready = 1'b0;
    check("t2_skip_valid", 32'(value_valid), 0);
    check("t2_skip_busy", 32'(busy), 1);
    check("t2_skip_ovf_clr", 32'(overflow), 0);
    tick();
    check("t2_skip_ready", 32'(digit_ready), 1);
    send(4'd5, 1'b0);
    send(4'd1, 1'b0);
    send(4'd3, 1'b0);
    tick();
    check("t2b_value", 32'(value), 511);
    check("t2b_overflow", 32'(overflow), 1);
    value_ready = 1'b1; tick(); value_ready = 1'b0;
    check("t2b_idle_busy", 32'(busy), 0);

    // out-of-range digit 12 then 3 last -> 3, bad_digit set
    start = 1'b1; tick(); start = 1'b0; tick();
    send(4'd12, 1'b0);
    check("t3_bad_sticky", 32'(bad_digit), 1);
    send(4'd3, 1'b1);
    tick();
    check("t3_value", 32'(value), 3);
    check("t3_bad_digit", 32'(bad_digit), 1);
    check("t3_overflow", 32'(overflow), 0);
    start = 1'b1; value_ready = 1'b1; tick();
    start = 1'b0; value_ready = 1'b0;
    check("t3_bad_cleared", 32'(bad_digit), 0);
    tick();

    // 9,9 then start with concurrent 4 (dropped), then 6 last -> 6
    send(4'd9, 1'b0);
    send(4'd9, 1'b0);
    start = 1'b1; digit = 4'd4; digit_valid = 1'b1; tick();
    start = 1'b0; digit_valid = 1'b0;
    check("t4_ready_after_restart", 32'(digit_ready), 1);
    check("t4_no_valid", 32'(value_valid), 0);
    send(4'd6, 1'b1);
    tick();
    check("t4_valid", 32'(value_valid), 1);
    check("t4_value", 32'(value), 6);

    // hold DONE 20 cycles with start ignored, then async reset mid-cycle
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t5_hold_value", 32'(value), 6);
      check("t5_hold_valid", 32'(value_valid), 1);
      check("t5_hold_ready", 32'(digit_ready), 0);
    end
    start = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_rst");
    tick();
    rst = 1'b0;
    tick();
    check("t5_post_rst_busy", 32'(busy), 0);
    check("t5_post_rst_valid", 32'(value_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
